// File: rtl/div_issue_pkg.sv
// Shared types and constants for the RV32M divider issue stage.
// Funct3 encodings and RISC-V special-case result values.
package div_issue_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DRAIN,
    RESP
  } state_t;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_issue_special_chk.sv
// Combinational classifier for illegal, divide-by-zero and overflow
// requests, producing the architectural result for those cases.
module div_special_chk
  import div_issue_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        is_illegal,
  output logic        is_zero_div,
  output logic        is_overflow,
  output logic [31:0] spec_data
);

  logic zero_hit;
  logic ovf_hit;

  assign is_illegal  = !op[2];
  assign is_zero_div = (op2 == '0);
  assign is_overflow = !op[0]
                    && (op1 == INT_MIN)
                    && (op2 == ALL_ONES);

  assign zero_hit = op[2] && is_zero_div;
  assign ovf_hit  = op[2] && is_overflow;

  // op[1] selects remainder over quotient
  always_comb begin
    spec_data = '0;
    unique case (1'b1)
      zero_hit:
        spec_data = op[1] ? op1 : ALL_ONES;
      ovf_hit:
        spec_data = op[1] ? '0 : INT_MIN;
      default:
        spec_data = '0;
    endcase
  end

endmodule

// File: rtl/div_issue.sv
// Issue/control stage in front of the iterative radix-2 divider.
// Resolves special cases locally, otherwise launches and waits.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             ext_stall,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_op1,
  input  logic [31:0]      req_op2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             div_valid,
  input  logic             div_ready,
  output logic             div_stall,
  output logic [2:0]       div_op,
  output logic [31:0]      div_op1,
  output logic [31:0]      div_op2,
  input  logic [31:0]      div_out
);

  state_t state;
  state_t state_nx;

  logic [2:0]       op_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic             ill_q;

  logic        is_illegal;
  logic        is_zero_div;
  logic        is_overflow;
  logic        is_special;
  logic [31:0] spec_data;
  logic        accept;
  logic        capture;
  logic        div_done;

  div_special_chk u_chk (
    .op          (req_op),
    .op1         (req_op1),
    .op2         (req_op2),
    .is_illegal  (is_illegal),
    .is_zero_div (is_zero_div),
    .is_overflow (is_overflow),
    .spec_data   (spec_data)
  );

  assign is_special = is_illegal
                   || is_zero_div
                   || is_overflow;

  assign req_ready = (state == IDLE)
                  && !ext_stall
                  && !flush;
  assign accept    = req_valid && req_ready;
  assign div_done  = div_ready && !ext_stall;
  assign capture   = (state == WAIT)
                  && div_done
                  && !flush;

  assign div_valid = (state == LAUNCH)
                  && !ext_stall
                  && !flush;
  assign rsp_valid = (state == RESP) && !flush;
  assign div_stall = ext_stall;

  assign div_op      = op_q;
  assign div_op1     = op1_q;
  assign div_op2     = op2_q;
  assign rsp_tag     = tag_q;
  assign rsp_data    = data_q;
  assign rsp_illegal = ill_q;

  // flush overrides stall so a kill pulse is never lost
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = is_special ? RESP : LAUNCH;
      LAUNCH:
        if (flush)
          state_nx = IDLE;
        else if (!ext_stall)
          state_nx = WAIT;
      WAIT:
        if (flush)
          state_nx = div_done ? IDLE : DRAIN;
        else if (capture)
          state_nx = RESP;
      DRAIN:
        if (div_done)
          state_nx = IDLE;
      RESP:
        if (flush)
          state_nx = IDLE;
        else if (rsp_ready && !ext_stall)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      op_q   <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= req_op;
        op1_q <= req_op1;
        op2_q <= req_op2;
        tag_q <= req_tag;
        ill_q <= is_illegal;
        if (is_special)
          data_q <= spec_data;
      end else if (capture) begin
        data_q <= div_out;
      end
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// Randomized self-checking bench for div_issue with a
// behavioural 32-cycle divider and RISC-V result model.
module tb_div_issue;

  localparam int TAG_W = 5;
  localparam logic [31:0] IMIN = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic             flush;
  logic             ext_stall;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_op1;
  logic [31:0]      req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;
  logic             div_valid;
  logic             div_ready;
  logic             div_stall;
  logic [2:0]       div_op;
  logic [31:0]      div_op1;
  logic [31:0]      div_op2;
  logic [31:0]      div_out;

  div_issue #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .ext_stall   (ext_stall),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_illegal (rsp_illegal),
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .div_stall   (div_stall),
    .div_op      (div_op),
    .div_op1     (div_op1),
    .div_op2     (div_op2),
    .div_out     (div_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (!op[2]) return '0;
    if (b == 0) return op[1] ? a : ONES;
    if (op[0]) return op[1] ? a % b : a / b;
    if (a == IMIN && b == ONES) return op[1] ? '0 : IMIN;
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // divider: busy 32 unstalled cycles, then result until consumed
  logic busy;
  int   cnt;
  always @(posedge clk) begin
    if (!rstn) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (!div_stall) begin
      if (div_valid) begin
        busy <= 1'b1;
        cnt  <= 0;
      end else if (busy) begin
        if (cnt == 32) busy <= 1'b0;
        else cnt <= cnt + 1;
      end
    end
  end
  assign div_ready = busy && (cnt == 32);
  assign div_out = div_ready
    ? ref_res(div_op, div_op1, div_op2)
    : 32'hDEAD_BEEF;

  int          pulses    = 0;
  int          stab_errs = 0;
  logic [2:0]  l_op;
  logic [31:0] l_op1;
  logic [31:0] l_op2;
  always @(posedge clk) begin
    if (div_valid) begin
      pulses <= pulses + 1;
      l_op   <= div_op;
      l_op1  <= div_op1;
      l_op2  <= div_op2;
    end
    if (busy && (div_op !== l_op
        || div_op1 !== l_op1
        || div_op2 !== l_op2))
      stab_errs <= stab_errs + 1;
  end

  function automatic logic rnd_stall(input bit st);
    return st && ($urandom_range(0, 3) == 0);
  endfunction

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [TAG_W-1:0] tag,
                        input int hold,
                        input bit st);
    logic [31:0] exp;
    bit special;
    bit bad;
    int cyc;
    int p0;
    int s0;
    exp = ref_res(op, a, b);
    special = !op[2] || b == 0
           || (!op[0] && a == IMIN && b == ONES);
    p0 = pulses;
    s0 = stab_errs;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_op1 = a;
    req_op2 = b;
    req_tag = tag;
    ext_stall = rnd_stall(st);
    #1;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      ext_stall = rnd_stall(st);
      #1;
      cyc++;
    end
    chk("accept", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_op1 = $urandom;
    req_op2 = $urandom;
    req_tag = TAG_W'($urandom);
    ext_stall = rnd_stall(st);
    #1;
    cyc = 1;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      ext_stall = rnd_stall(st);
      #1;
      cyc++;
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    if (!st) chk("latency", cyc, special ? 1 : 35);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_tag", 32'(rsp_tag), 32'(tag));
    chk("rsp_illegal", 32'(rsp_illegal), 32'(!op[2]));
    bad = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ext_stall = rnd_stall(st);
      #1;
      if (!rsp_valid || rsp_data !== exp
          || rsp_tag !== tag || req_ready)
        bad = 1;
    end
    chk("hold", 32'(bad), 0);
    ext_stall = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("handshake", 32'(rsp_valid), 0);
    chk("pulses", pulses - p0, special ? 0 : 1);
    chk("stable", stab_errs - s0, 0);
  endtask

  task automatic accept_req(input logic [2:0] op,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_op1 = a;
    req_op2 = b;
    req_tag = tag;
    ext_stall = 1'b0;
    #1;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("acc_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    bit bad2;
    int p0;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    rstn = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_op1 = '0;
    req_op2 = '0;
    req_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_div_valid", 32'(div_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", 32'(rsp_tag), 0);
    chk("rst_illegal", 32'(rsp_illegal), 0);
    chk("rst_div_op1", div_op1, 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    rstn = 1'b1;

    run_op(3'b100, 100, 7, 3, 0, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 2, 4, 1, 0);
    run_op(3'b101, ONES, 2, 5, 0, 0);
    run_op(3'b101, 5, 0, 6, 0, 0);
    run_op(3'b100, IMIN, ONES, 7, 0, 0);
    run_op(3'b110, IMIN, ONES, 8, 2, 0);
    run_op(3'b011, 9, 3, 9, 0, 0);
    run_op(3'b100, 500, 3, 10, 5, 1);

    // flush in LAUNCH suppresses the pulse
    p0 = pulses;
    accept_req(3'b100, 50, 5, 1);
    flush = 1'b1;
    #1;
    chk("fl_launch_dv", 32'(div_valid), 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_launch_idle", 32'(req_ready), 1);
    repeat (40) @(negedge clk);
    chk("fl_launch_pulses", pulses - p0, 0);

    // flush in RESP beats rsp_ready
    accept_req(3'b101, 5, 0, 2);
    #1;
    chk("fl_resp_pre", 32'(rsp_valid), 1);
    flush = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("fl_resp_drop", 32'(rsp_valid), 0);
    @(negedge clk);
    flush = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("fl_resp_idle", 32'(rsp_valid), 0);
    chk("fl_resp_ready", 32'(req_ready), 1);

    // flush in WAIT drains the divider
    accept_req(3'b100, 1000, 3, 11);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bad = 0;
    bad2 = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (rsp_valid) bad = 1;
      if (req_ready && busy) bad2 = 1;
      @(negedge clk);
    end
    chk("drain_no_rsp", 32'(bad), 0);
    chk("drain_blocked", 32'(bad2), 0);
    run_op(3'b100, 9, 3, 12, 0, 0);

    // reset mid-WAIT
    run_op(3'b110, 5, 0, 13, 0, 0);
    accept_req(3'b100, 77, 7, 9);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_div_valid", 32'(div_valid), 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_tag", 32'(rsp_tag), 0);
    chk("mid_rst_div_op", 32'(div_op), 0);
    chk("mid_rst_div_op1", div_op1, 0);
    chk("mid_rst_div_op2", div_op2, 0);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_ready", 32'(req_ready), 1);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 0;
      if (sel == 1) begin
        a = IMIN;
        b = ONES;
      end
      if (sel == 2) b = $urandom_range(1, 9);
      if ($urandom_range(0, 9) == 0)
        op = {1'b0, 2'($urandom)};
      else
        op = {1'b1, 2'($urandom)};
      run_op(op, a, b, TAG_W'($urandom),
             $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
